alu_rs_scheduler: RTL
=====================

// Module: alu_rs_scheduler
// PURPOSE
//  ALU reservation station and issue scheduler. Buffers dispatched ALU-class ops (branch, jump, I/R/U arithmetic).
//  Wakes source operands by snooping the ALU and LSB common-data-bus broadcasts.
//  Each cycle it selects one ready entry and drives the registered op/operand bundle plus the new_calculate strobe
//  into the combinational ALU. Sits between decoder/dispatch and the ALU; the ALU result returns on the ALU CDB.
// PARAMETERS
//  RS_SIZE   16  number of station entries (power of 2, >=2)
//  TAG_W     4   ROB tag width; `ENTRY_RANGE == [TAG_W-1:0]
// PORTS
//  clk_in          in   1      system clock; all state updates on rising edge
//  rst_in          in   1      reset, synchronous, active-low
//  rdy_in          in   1      ready; low pauses the block
//  clear_in        in   1      mispredict flush, synchronous
//  disp_valid      in   1      dispatch request this cycle
//  disp_op         in   6      op code (operaType.v encoding)
//  disp_inst       in   32     raw instruction (shamt at [24:20])
//  disp_vj/vk      in   32     operand values, valid when matching q*_busy=0
//  disp_qj_busy    in   1      vj pending
//  disp_qk_busy    in   1      vk pending
//  disp_qj/qk      in   TAG_W  producing ROB tags
//  disp_pc, disp_imm in 32     pc and sign-extended immediate
//  disp_entry      in   TAG_W  destination ROB tag
//  rs_full         out  1      no free entry (combinational from busy vector)
//  alu_cdb_valid   in   1      ALU broadcast; alu_cdb_entry in TAG_W; alu_cdb_value in 32
//  lsb_cdb_valid   in   1      LSB broadcast; lsb_cdb_entry in TAG_W; lsb_cdb_value in 32
//  new_calculate   out  1      one-cycle issue strobe to ALU (reg)
//  alu_op          out  6      issued op (reg); alu_inst/vj/vk/pc/imm out 32 (reg)
//  alu_entry       out  TAG_W  issued ROB tag (reg)
// BEHAVIOUR
//  Reset (rst_in==0 at edge):
//   - all busy=0; new_calculate=0; alu_op/inst/vj/vk/pc/imm/entry=0; rs_full=0.
//   - Reset overrides clear_in and rdy_in.
//  Priority, highest first: reset > rdy_in==0 > clear_in > normal.
//   - rdy_in==0: all state holds; new_calculate is cleared to 0 so no duplicate ALU broadcast.
//   - clear_in==1 (rdy_in high): all busy=0, new_calculate=0; same-cycle dispatch dropped.
//  Dispatch:
//   - if disp_valid && !rs_full, write the lowest-index free entry, busy=1.
//   - disp_valid while rs_full is ignored; dispatch must not request while rs_full.
//   - Bypass: if disp_q*_busy and a same-cycle CDB tag matches, store the CDB value and mark the operand ready.
//     If both CDBs match, ALU CDB wins.
//  Wakeup: every busy entry with qj/qk busy and tag == a valid CDB tag captures the value and clears q*_busy.
//  Issue select:
//   - ready = busy && !qj_busy && !qk_busy, from registered state.
//   - Same-cycle wakeup or dispatch issues no earlier than the next cycle.
//   - Lowest-index ready entry wins; one issue per cycle.
//   - On issue: outputs load the entry fields, new_calculate=1 for exactly one cycle, entry busy=0 at the same edge.
//   - No ready entry: new_calculate=0, payload regs hold.
//  Latency: dispatch with ready operands at edge N -> new_calculate high during cycle N+1 to N+2
//   (issue at N+1 edge, visible N+1..N+2).
//  Free-entry search uses pre-edge busy: an entry issued this edge is not reusable until next cycle.
//  Unused operands (U/J formats, I-format vk) must be dispatched with q*_busy=0.
//  Tag 0 is a valid tag; readiness is held only in the q*_busy flags.
// TESTING
//  1. Reset with rdy_in=1, then dispatch ADD vj=5 vk=7 entry=3 both ready
//     -> next edge new_calculate=1, alu_op=ADD, alu_vj=5, alu_vk=7, alu_entry=3; strobe low the following cycle.
//  2. Dispatch SUB qj_busy tag=2 into entry 0, READY ADDI into entry 1
//     -> ADDI issues first; then alu_cdb_valid tag=2 value=9 -> SUB issues next cycle with alu_vj=9.
//  3. Fill all 16 entries with qj_busy tag=5 -> rs_full=1; a 17th disp_valid is ignored;
//     lsb_cdb tag=5 value=1 -> entries issue in index order 0..15 on 16 consecutive cycles.
//  4. Dispatch BEQ qk_busy tag=4 same cycle as alu_cdb tag=4 value=0x10 -> entry stored ready;
//     issues with alu_vk=0x10 one cycle later.
//  5. Four busy entries, drop rdy_in for 3 cycles -> new_calculate=0, state frozen;
//     raise rdy_in -> issue resumes from the lowest-index ready entry.
//  6. clear_in with pending entries plus simultaneous dispatch -> next cycle rs_full=0, new_calculate=0, nothing issues;
//     rst_in=0 mid-issue -> all outputs 0 next edge.

Source files
------------

// File: rtl/alu_rs_scheduler.sv
// ALU reservation station: buffers dispatched ALU ops, wakes operands from the ALU/LSB CDBs,
// and issues the lowest-index ready entry into the ALU each cycle through registered outputs.
module alu_rs_scheduler #(
  parameter int unsigned RS_SIZE = 16,
  parameter int unsigned TAG_W   = 4
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              rdy_in,
  input  logic              clear_in,
  input  logic              disp_valid,
  input  logic [5:0]        disp_op,
  input  logic [31:0]       disp_inst,
  input  logic [31:0]       disp_vj,
  input  logic [31:0]       disp_vk,
  input  logic              disp_qj_busy,
  input  logic              disp_qk_busy,
  input  logic [TAG_W-1:0]  disp_qj,
  input  logic [TAG_W-1:0]  disp_qk,
  input  logic [31:0]       disp_pc,
  input  logic [31:0]       disp_imm,
  input  logic [TAG_W-1:0]  disp_entry,
  output logic              rs_full,
  input  logic              alu_cdb_valid,
  input  logic [TAG_W-1:0]  alu_cdb_entry,
  input  logic [31:0]       alu_cdb_value,
  input  logic              lsb_cdb_valid,
  input  logic [TAG_W-1:0]  lsb_cdb_entry,
  input  logic [31:0]       lsb_cdb_value,
  output logic              new_calculate,
  output logic [5:0]        alu_op,
  output logic [31:0]       alu_inst,
  output logic [31:0]       alu_vj,
  output logic [31:0]       alu_vk,
  output logic [31:0]       alu_pc,
  output logic [31:0]       alu_imm,
  output logic [TAG_W-1:0]  alu_entry
);

  localparam int unsigned IDX_W = $clog2(RS_SIZE);

  logic [RS_SIZE-1:0] busy_q, qj_busy_q, qk_busy_q;
  logic [5:0]         op_q    [RS_SIZE];
  logic [31:0]        inst_q  [RS_SIZE];
  logic [31:0]        vj_q    [RS_SIZE];
  logic [31:0]        vk_q    [RS_SIZE];
  logic [31:0]        pc_q    [RS_SIZE];
  logic [31:0]        imm_q   [RS_SIZE];
  logic [TAG_W-1:0]   qj_q    [RS_SIZE];
  logic [TAG_W-1:0]   qk_q    [RS_SIZE];
  logic [TAG_W-1:0]   entry_q [RS_SIZE];

  logic [RS_SIZE-1:0] ready;
  logic [IDX_W-1:0]   free_idx, issue_idx;
  logic               issue_any;
  logic [31:0]        fwd_vj, fwd_vk;
  logic               fwd_qj_busy, fwd_qk_busy;

  assign rs_full   = &busy_q;
  assign ready     = busy_q & ~qj_busy_q & ~qk_busy_q;
  assign issue_any = |ready;

  // Descending scan so the lowest index is the last (winning) assignment.
  always_comb begin
    free_idx  = '0;
    issue_idx = '0;
    for (int i = RS_SIZE - 1; i >= 0; i--) begin
      if (!busy_q[i]) free_idx = IDX_W'(i);
      if (ready[i])   issue_idx = IDX_W'(i);
    end
  end

  // Same-cycle CDB bypass for dispatched operands; ALU CDB takes precedence.
  always_comb begin
    fwd_vj      = disp_vj;
    fwd_qj_busy = disp_qj_busy;
    fwd_vk      = disp_vk;
    fwd_qk_busy = disp_qk_busy;
    if (disp_qj_busy) begin
      if (alu_cdb_valid && alu_cdb_entry == disp_qj) begin
        fwd_vj      = alu_cdb_value;
        fwd_qj_busy = 1'b0;
      end else if (lsb_cdb_valid && lsb_cdb_entry == disp_qj) begin
        fwd_vj      = lsb_cdb_value;
        fwd_qj_busy = 1'b0;
      end
    end
    if (disp_qk_busy) begin
      if (alu_cdb_valid && alu_cdb_entry == disp_qk) begin
        fwd_vk      = alu_cdb_value;
        fwd_qk_busy = 1'b0;
      end else if (lsb_cdb_valid && lsb_cdb_entry == disp_qk) begin
        fwd_vk      = lsb_cdb_value;
        fwd_qk_busy = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      busy_q        <= '0;
      qj_busy_q     <= '0;
      qk_busy_q     <= '0;
      new_calculate <= 1'b0;
      alu_op        <= '0;
      alu_inst      <= '0;
      alu_vj        <= '0;
      alu_vk        <= '0;
      alu_pc        <= '0;
      alu_imm       <= '0;
      alu_entry     <= '0;
      for (int i = 0; i < RS_SIZE; i++) begin
        op_q[i]    <= '0;
        inst_q[i]  <= '0;
        vj_q[i]    <= '0;
        vk_q[i]    <= '0;
        pc_q[i]    <= '0;
        imm_q[i]   <= '0;
        qj_q[i]    <= '0;
        qk_q[i]    <= '0;
        entry_q[i] <= '0;
      end
    end else if (!rdy_in) begin
      new_calculate <= 1'b0;
    end else if (clear_in) begin
      busy_q        <= '0;
      new_calculate <= 1'b0;
    end else begin
      new_calculate <= issue_any;
      if (issue_any) begin
        alu_op            <= op_q[issue_idx];
        alu_inst          <= inst_q[issue_idx];
        alu_vj            <= vj_q[issue_idx];
        alu_vk            <= vk_q[issue_idx];
        alu_pc            <= pc_q[issue_idx];
        alu_imm           <= imm_q[issue_idx];
        alu_entry         <= entry_q[issue_idx];
        busy_q[issue_idx] <= 1'b0;
      end

      for (int i = 0; i < RS_SIZE; i++) begin
        if (busy_q[i] && qj_busy_q[i]) begin
          if (alu_cdb_valid && alu_cdb_entry == qj_q[i]) begin
            vj_q[i]      <= alu_cdb_value;
            qj_busy_q[i] <= 1'b0;
          end else if (lsb_cdb_valid && lsb_cdb_entry == qj_q[i]) begin
            vj_q[i]      <= lsb_cdb_value;
            qj_busy_q[i] <= 1'b0;
          end
        end
        if (busy_q[i] && qk_busy_q[i]) begin
          if (alu_cdb_valid && alu_cdb_entry == qk_q[i]) begin
            vk_q[i]      <= alu_cdb_value;
            qk_busy_q[i] <= 1'b0;
          end else if (lsb_cdb_valid && lsb_cdb_entry == qk_q[i]) begin
            vk_q[i]      <= lsb_cdb_value;
            qk_busy_q[i] <= 1'b0;
          end
        end
      end

      // free_idx is never busy, so this cannot collide with issue or wakeup writes.
      if (disp_valid && !rs_full) begin
        busy_q[free_idx]    <= 1'b1;
        op_q[free_idx]      <= disp_op;
        inst_q[free_idx]    <= disp_inst;
        vj_q[free_idx]      <= fwd_vj;
        vk_q[free_idx]      <= fwd_vk;
        qj_busy_q[free_idx] <= fwd_qj_busy;
        qk_busy_q[free_idx] <= fwd_qk_busy;
        qj_q[free_idx]      <= disp_qj;
        qk_q[free_idx]      <= disp_qk;
        pc_q[free_idx]      <= disp_pc;
        imm_q[free_idx]     <= disp_imm;
        entry_q[free_idx]   <= disp_entry;
      end
    end
  end

endmodule
